// File: rtl/minimig_reset_requester.sv
// Master-reset initiator: merges keyboard, host/OSD and 68k RESET requests,
// drives a minimum-width mrst pulse and watches sys_reset for completion/fault.
module minimig_reset_requester #(
  parameter int DEB_TICKS  = 8,
  parameter int HOLD_TICKS = 16,
  parameter int TIMEOUT    = 1024
)(
  input  logic       clk,
  input  logic       _reset,
  input  logic       clk7_en,
  input  logic       kbd_rst,
  input  logic       host_rst,
  input  logic       cpu_rst,
  input  logic       sys_reset,
  output logic       mrst,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] rst_src
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_TICKS);
  // Loaded with N-1: the exit test happens on the tick after the count hits
  // zero, so a load of N-1 gives exactly N ticks in the state.
  localparam logic [15:0] HOLD_LD = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] TMO_LD  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ksync;
  logic [DW-1:0]   deb_cnt;
  logic            kbd_req;
  logic            host_pend, cpu_pend;
  logic            req;
  logic [1:0]      src_nxt;
  logic [15:0]     hold_cnt, tmo_cnt;
  logic            sys_seen;

  assign busy = (state != S_IDLE);
  assign mrst = (state == S_ASSERT);
  assign done = (state == S_DONE);

  // Two-flop synchroniser for the asynchronous keyboard level, on the 7MHz enable.
  always_ff @(posedge clk or negedge _reset)
    if (!_reset)      ksync <= '0;
    else if (clk7_en) ksync <= {ksync[0], kbd_rst};

  // Debounce: count while the key is held, saturate at DEB_TICKS, clear on release.
  always_ff @(posedge clk or negedge _reset)
    if (!_reset)                 deb_cnt <= '0;
    else if (clk7_en) begin
      if (!ksync[1])             deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
    end

  assign kbd_req = (deb_cnt == DEB_MAX);
  assign req     = host_pend | kbd_req | cpu_pend;
  // Simultaneous requests: host wins over keyboard, keyboard over cpu.
  assign src_nxt = host_pend ? 2'b01 : (kbd_req ? 2'b10 : 2'b11);

  // Pulse requests are caught on any clk; pulses seen while busy are dropped,
  // and acceptance clears every pending flag (losers are not queued).
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      host_pend <= 1'b0;
      cpu_pend  <= 1'b0;
    end else if (busy || (clk7_en && req)) begin
      host_pend <= 1'b0;
      cpu_pend  <= 1'b0;
    end else begin
      if (host_rst) host_pend <= 1'b1;
      if (cpu_rst)  cpu_pend  <= 1'b1;
    end

  // State register.
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) state <= S_IDLE;
    else         state <= state_nxt;

  // Next-state logic; moves only on clk7_en ticks.
  always_comb begin
    state_nxt = state;
    if (clk7_en) begin
      unique case (state)
        S_IDLE:    if (req) state_nxt = S_ASSERT;
        // A held keyboard keeps mrst asserted past the minimum hold.
        S_ASSERT:  if (hold_cnt == '0 && !kbd_req) state_nxt = S_RELEASE;
        S_RELEASE: if (!sys_reset) state_nxt = S_DONE;
                   else if (tmo_cnt == '0) state_nxt = S_IDLE;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, source latch and sticky fault flag.
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      hold_cnt <= '0;
      tmo_cnt  <= '0;
      sys_seen <= 1'b0;
      err      <= 1'b0;
      rst_src  <= 2'b00;
    end else if (clk7_en) begin
      unique case (state)
        S_IDLE: if (req) begin
          rst_src  <= src_nxt;
          err      <= 1'b0;
          hold_cnt <= HOLD_LD;
          sys_seen <= 1'b0;
        end
        S_ASSERT: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 16'd1;
          sys_seen <= sys_seen | sys_reset;
          if (state_nxt == S_RELEASE) begin
            tmo_cnt <= TMO_LD;
            // The generator never acknowledged: flag it but still finish the cycle.
            if (!(sys_seen || sys_reset)) err <= 1'b1;
          end
        end
        S_RELEASE: if (sys_reset) begin
          if (tmo_cnt == '0) err <= 1'b1;
          else               tmo_cnt <= tmo_cnt - 16'd1;
        end
        default: ;
      endcase
    end

endmodule
